// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared types and defaults for the key event arbiter
package key_event_pkg;

  localparam int NUM_KEYS_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/key_release_detect.sv
// rtl/key_release_detect.sv - per-key sampler with 1->0 release pulse
// KEY_DEBOUNCE_EN: the sample only follows the key after DEBOUNCE_CYCLES stable mismatching cycles
module key_release_detect
`ifdef KEY_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk_i,
  input  logic resetn_i,
  input  logic key_i,
  output logic rel_o
);

  logic key_s_q;
  logic key_q_q;

`ifdef KEY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Any cycle where the key agrees with the sample restarts the stability count
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      key_s_q <= 1'b0;
      cnt_q   <= '0;
    end else if (key_i == key_s_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      key_s_q <= key_i;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      key_s_q <= 1'b0;
    end else begin
      key_s_q <= key_i;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      key_q_q <= 1'b0;
    end else begin
      key_q_q <= key_s_q;
    end
  end

  assign rel_o = key_q_q & ~key_s_q;

endmodule

// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - queues key releases and serialises them round-robin onto one valid/ready port
// KEY_DEBOUNCE_EN: enables per-key debounce in key_release_detect
module key_event_arbiter
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEF,
  parameter int IDX_W    = $clog2(NUM_KEYS)
`ifdef KEY_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [IDX_W-1:0]    ev_idx,
  output logic [NUM_KEYS-1:0] pending,
  output logic                overrun
);

  logic [NUM_KEYS-1:0] rel;
  logic [NUM_KEYS-1:0] clr;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    grant;
  logic                found;
  logic                hs;
  logic                overrun_q, overrun_d;
  int                  cand;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_det
    key_release_detect
`ifdef KEY_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_det (
        .clk_i   (Clock),
        .resetn_i(Reset),
        .key_i   (key[i]),
        .rel_o   (rel[i])
      );
  end

  // Round-robin search starting at ptr; wrap is explicit for non-power-of-2 key counts
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = 0;
    for (int o = 0; o < NUM_KEYS; o++) begin
      cand = int'(ptr_q) + o;
      if (cand >= NUM_KEYS) cand = cand - NUM_KEYS;
      if (!found && pending_q[IDX_W'(cand)]) begin
        grant = IDX_W'(cand);
        found = 1'b1;
      end
    end
  end

  // A release landing on the delivery cycle re-arms the flag rather than counting as overrun
  always_comb begin
    hs  = (state_q == OFFER) && ev_ready;
    clr = '0;
    if (hs) clr[idx_q] = 1'b1;
    pending_d = (pending_q & ~clr) | rel;
    overrun_d = |(rel & pending_q & ~clr);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = grant;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          state_d = IDLE;
          ptr_d   = (int'(idx_q) == NUM_KEYS - 1) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign ev_valid = (state_q == OFFER);
  assign ev_idx   = idx_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - directed self-checking bench for key_event_arbiter
module tb_key_event_arbiter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] key = 4'b1111;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_idx;
  logic [3:0] pending;
  logic       overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clock = ~Clock;

  key_event_arbiter dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .key     (key),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_idx  (ev_idx),
    .pending (pending),
    .overrun (overrun)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    int seen;
    Reset = 1'b0; key = 4'b1111; ev_ready = 1'b0;
    tick(); tick();
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ev_valid); else pass_cnt++;
    total_cnt++; if (pending !== 4'b0000) $display("FAIL reset_pending: got %b want 0000", pending); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (ev_idx !== 2'd0) $display("FAIL reset_idx: got %0d want 0", ev_idx); else pass_cnt++;
    Reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ev_valid !== 1'b0) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL held_keys_valid: got %0d events want 0", seen); else pass_cnt++;
    total_cnt++; if (pending !== 4'b0000) $display("FAIL held_keys_pending: got %b want 0000", pending); else pass_cnt++;
  endtask

  task automatic test_single_release();
    ev_ready = 1'b1;
    key = 4'b1011;
    tick(); tick();
    total_cnt++; if (pending !== 4'b0100) $display("FAIL single_pending: got %b want 0100", pending); else pass_cnt++;
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", ev_valid); else pass_cnt++;
    tick();
    total_cnt++; if (ev_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", ev_valid); else pass_cnt++;
    total_cnt++; if (ev_idx !== 2'd2) $display("FAIL single_idx: got %0d want 2", ev_idx); else pass_cnt++;
    tick();
    total_cnt++; if (pending !== 4'b0000) $display("FAIL single_clear: got %b want 0000", pending); else pass_cnt++;
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL single_drop: got %b want 0", ev_valid); else pass_cnt++;
    key = 4'b1111;
    repeat (4) tick();
  endtask

  task automatic test_simultaneous();
    int n;
    logic [1:0] got [4];
    for (int i = 0; i < 4; i++) got[i] = 2'd0;
    Reset = 1'b0; tick(); Reset = 1'b1;
    repeat (4) tick();
    ev_ready = 1'b1;
    key = 4'b0100;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ev_valid === 1'b1) begin
        if (n < 4) got[n] = ev_idx;
        n++;
      end
    end
    total_cnt++; if (n !== 3) $display("FAIL rr_count: got %0d want 3", n); else pass_cnt++;
    total_cnt++; if (got[0] !== 2'd0) $display("FAIL rr_first: got %0d want 0", got[0]); else pass_cnt++;
    total_cnt++; if (got[1] !== 2'd1) $display("FAIL rr_second: got %0d want 1", got[1]); else pass_cnt++;
    total_cnt++; if (got[2] !== 2'd3) $display("FAIL rr_third: got %0d want 3", got[2]); else pass_cnt++;
    key = 4'b1111;
    repeat (3) tick();
    key = 4'b1110;
    n = 0;
    got[0] = 2'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ev_valid === 1'b1) begin
        if (n < 4) got[n] = ev_idx;
        n++;
      end
    end
    total_cnt++; if (n !== 1) $display("FAIL wrap_count: got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (got[0] !== 2'd0) $display("FAIL wrap_idx: got %0d want 0", got[0]); else pass_cnt++;
    key = 4'b1111;
    repeat (3) tick();
  endtask

  task automatic test_hold_overrun();
    int unstable;
    int ov_n;
    int seen;
    ev_ready = 1'b0;
    key = 4'b1101;
    repeat (3) tick();
    total_cnt++; if (ev_valid !== 1'b1) $display("FAIL hold_valid: got %b want 1", ev_valid); else pass_cnt++;
    total_cnt++; if (ev_idx !== 2'd1) $display("FAIL hold_idx: got %0d want 1", ev_idx); else pass_cnt++;
    unstable = 0;
    ov_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) key = 4'b1111;
      if (i == 4) key = 4'b1101;
      tick();
      if (ev_valid !== 1'b1 || ev_idx !== 2'd1) unstable++;
      if (overrun === 1'b1) ov_n++;
    end
    total_cnt++; if (unstable !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); else pass_cnt++;
    total_cnt++; if (ov_n !== 1) $display("FAIL overrun_pulse: got %0d cycles want 1", ov_n); else pass_cnt++;
    total_cnt++; if (pending !== 4'b0010) $display("FAIL hold_pending: got %b want 0010", pending); else pass_cnt++;
    ev_ready = 1'b1;
    tick();
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL hold_accept: got %b want 0", ev_valid); else pass_cnt++;
    total_cnt++; if (pending !== 4'b0000) $display("FAIL hold_clear: got %b want 0000", pending); else pass_cnt++;
    key = 4'b1111;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ev_valid === 1'b1) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL merged_events: got %0d extra events want 0", seen); else pass_cnt++;
  endtask

  task automatic test_set_clear_collision();
    ev_ready = 1'b0;
    key = 4'b1101;
    repeat (3) tick();
    total_cnt++; if (ev_valid !== 1'b1 || ev_idx !== 2'd1) $display("FAIL coll_offer: got valid %b idx %0d want 1/1", ev_valid, ev_idx); else pass_cnt++;
    key = 4'b1111;
    tick(); tick();
    key = 4'b1101;
    tick();
    ev_ready = 1'b1;
    tick();
    total_cnt++; if (pending !== 4'b0010) $display("FAIL coll_pending: got %b want 0010", pending); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL coll_overrun: got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL coll_bubble: got %b want 0", ev_valid); else pass_cnt++;
    tick();
    total_cnt++; if (ev_valid !== 1'b1) $display("FAIL coll_reoffer_valid: got %b want 1", ev_valid); else pass_cnt++;
    total_cnt++; if (ev_idx !== 2'd1) $display("FAIL coll_reoffer_idx: got %0d want 1", ev_idx); else pass_cnt++;
    tick();
    total_cnt++; if (pending !== 4'b0000) $display("FAIL coll_final_pending: got %b want 0000", pending); else pass_cnt++;
    total_cnt++; if (ev_valid !== 1'b0) $display("FAIL coll_final_valid: got %b want 0", ev_valid); else pass_cnt++;
    key = 4'b1111;
    repeat (3) tick();
  endtask

`ifdef KEY_DEBOUNCE_EN
  task automatic test_debounce();
    int seen;
    key = 4'b1111;
    repeat (25) tick();
    ev_ready = 1'b1;
    key = 4'b1101;
    repeat (5) tick();
    key = 4'b1111;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ev_valid === 1'b1) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL glitch_events: got %0d want 0", seen); else pass_cnt++;
    total_cnt++; if (pending !== 4'b0000) $display("FAIL glitch_pending: got %b want 0000", pending); else pass_cnt++;
    key = 4'b1101;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) key = 4'b1111;
      tick();
      if (ev_valid === 1'b1) seen++;
    end
    total_cnt++; if (seen !== 1) $display("FAIL debounced_events: got %0d want 1", seen); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef KEY_DEBOUNCE_EN
    test_debounce();
`else
    test_single_release();
    test_simultaneous();
    test_hold_overrun();
    test_set_clear_collision();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
